// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: built-in self-test sequencer for the 64-bit ALU port.
// Drives LFSR-generated operand pairs through AND/OR/ADD/SUB (plus SLT when
// the ALU_BIST_SLT_EN macro is defined), checks each result and zero flag
// against an internal golden model, and reports pass/fail, a saturating
// failure count and the first failing vector.
module alu_bist_ctrl #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [63:0] SEED_A      = 64'h0123_4567_89AB_CDEF,
  parameter logic [63:0] SEED_B      = 64'hFEDC_BA98_7654_3210
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [63:0] alu_res,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] fail_count,
  output logic [3:0]  first_fail_op,
  output logic [63:0] first_fail_a,
  output logic [63:0] first_fail_b
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [63:0] SEED_A_EFF = (SEED_A == 64'd0) ? 64'd1 : SEED_A;
  localparam logic [63:0] SEED_B_EFF = (SEED_B == 64'd0) ? 64'd1 : SEED_B;

  // Right-shift Galois taps for x^64 + x^63 + x^61 + x^60 + 1.
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

`ifdef ALU_BIST_SLT_EN
  localparam logic [2:0] LAST_OP = 3'd4;
`else
  localparam logic [2:0] LAST_OP = 3'd3;
`endif

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One Galois LFSR step.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    logic [63:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ LFSR_TAPS;
    end
    return r;
  endfunction

  // Operation code for a given operation index; never yields an unused code.
  function automatic logic [3:0] op_code(input logic [2:0] idx);
    logic [3:0] c;
    case (idx)
      3'd0:    c = 4'b0000;
      3'd1:    c = 4'b0001;
      3'd2:    c = 4'b0010;
      3'd3:    c = 4'b0110;
`ifdef ALU_BIST_SLT_EN
      3'd4:    c = 4'b0111;
`endif
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // Reference ALU result; ADD/SUB wrap modulo 2^64.
  function automatic logic [63:0] golden(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [3:0]  ctrl);
    logic [63:0] r;
    case (ctrl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
`ifdef ALU_BIST_SLT_EN
      4'b0111: r = {63'd0, ($signed(a) < $signed(b))};
`endif
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [63:0] lfsr_a_q, lfsr_a_d;
  logic [63:0] lfsr_b_q, lfsr_b_d;
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [2:0]  op_idx_q, op_idx_d;
  logic [63:0] alu_a_q, alu_a_d;
  logic [63:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [15:0] fail_count_q, fail_count_d;
  logic [3:0]  ff_op_q, ff_op_d;
  logic [63:0] ff_a_q, ff_a_d;
  logic [63:0] ff_b_q, ff_b_d;
  logic        pass_q, pass_d;

  logic [63:0] exp_res;
  logic        exp_zero;
  logic        mismatch;
  logic        last_vec;
  logic [63:0] lfsr_a_nxt;
  logic [63:0] lfsr_b_nxt;
  logic [15:0] vec_nxt;
  logic [2:0]  op_nxt;

  assign exp_res    = golden(alu_a_q, alu_b_q, alu_ctrl_q);
  assign exp_zero   = (exp_res == 64'd0);
  assign mismatch   = (alu_res != exp_res) || (alu_zero != exp_zero);
  assign last_vec   = (vec_cnt_q == LAST_VEC) && (op_idx_q == LAST_OP);
  assign lfsr_a_nxt = lfsr_step(lfsr_a_q);
  assign lfsr_b_nxt = lfsr_step(lfsr_b_q);
  assign vec_nxt    = (vec_cnt_q == LAST_VEC) ? 16'd0 : vec_cnt_q + 16'd1;
  assign op_nxt     = (vec_cnt_q == LAST_VEC) ? op_idx_q + 3'd1 : op_idx_q;

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is honoured only outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_vec) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load on start, check-and-advance in RUN.
  always_comb begin
    lfsr_a_d     = lfsr_a_q;
    lfsr_b_d     = lfsr_b_q;
    vec_cnt_d    = vec_cnt_q;
    op_idx_d     = op_idx_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    fail_count_d = fail_count_q;
    ff_op_d      = ff_op_q;
    ff_a_d       = ff_a_q;
    ff_b_d       = ff_b_q;
    pass_d       = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Vector 0 of op 0 uses LFSR_A for both operands.
          lfsr_a_d     = SEED_A_EFF;
          lfsr_b_d     = SEED_B_EFF;
          vec_cnt_d    = 16'd0;
          op_idx_d     = 3'd0;
          alu_a_d      = SEED_A_EFF;
          alu_b_d      = SEED_A_EFF;
          alu_ctrl_d   = op_code(3'd0);
          fail_count_d = 16'd0;
          ff_op_d      = 4'd0;
          ff_a_d       = 64'd0;
          ff_b_d       = 64'd0;
          pass_d       = 1'b0;
        end
      end
      ST_RUN: begin
        if (mismatch) begin
          if (fail_count_q != CNT_MAX) begin
            fail_count_d = fail_count_q + 16'd1;
          end
          // A non-zero count means the first failure was already captured.
          if (fail_count_q == 16'd0) begin
            ff_op_d = alu_ctrl_q;
            ff_a_d  = alu_a_q;
            ff_b_d  = alu_b_q;
          end
        end
        if (last_vec) begin
          // Operands hold the final vector once the run ends.
          pass_d = (fail_count_d == 16'd0);
        end else begin
          lfsr_a_d   = lfsr_a_nxt;
          lfsr_b_d   = lfsr_b_nxt;
          vec_cnt_d  = vec_nxt;
          op_idx_d   = op_nxt;
          alu_a_d    = lfsr_a_nxt;
          alu_b_d    = (vec_nxt == 16'd0) ? lfsr_a_nxt : lfsr_b_nxt;
          alu_ctrl_d = op_code(op_nxt);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; everything clears on reset so no partial result survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a_q     <= 64'd0;
      lfsr_b_q     <= 64'd0;
      vec_cnt_q    <= 16'd0;
      op_idx_q     <= 3'd0;
      alu_a_q      <= 64'd0;
      alu_b_q      <= 64'd0;
      alu_ctrl_q   <= 4'd0;
      fail_count_q <= 16'd0;
      ff_op_q      <= 4'd0;
      ff_a_q       <= 64'd0;
      ff_b_q       <= 64'd0;
      pass_q       <= 1'b0;
    end else begin
      lfsr_a_q     <= lfsr_a_d;
      lfsr_b_q     <= lfsr_b_d;
      vec_cnt_q    <= vec_cnt_d;
      op_idx_q     <= op_idx_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      fail_count_q <= fail_count_d;
      ff_op_q      <= ff_op_d;
      ff_a_q       <= ff_a_d;
      ff_b_q       <= ff_b_d;
      pass_q       <= pass_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_control   = alu_ctrl_q;
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign pass          = pass_q;
  assign fail_count    = fail_count_q;
  assign first_fail_op = ff_op_q;
  assign first_fail_a  = ff_a_q;
  assign first_fail_b  = ff_b_q;

endmodule
